// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prio_pkg
// Description : Shared definitions for the priority arbiter: selection-mode
//               encodings and the winner-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package prio_pkg;

  // Selection mode as seen on the arbiter's mode input.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : prio_pkg
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : prio_pick
// Description : Combinational picker. Returns the highest index i for which
//               req[i] & mask[i] is set, and a flag saying whether any was.
// Ports       : req   [N-1:0]    request vector
//               mask  [N-1:0]    qualifying mask applied to req
//               found            at least one masked request is set
//               idx   [IDXW-1:0] highest masked set index (0 when !found)
// Revision    : 1.0 - initial release
// ============================================================================
module prio_pick
  import prio_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  // Ascending scan: the last hit overwrites earlier ones, leaving the highest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && mask[i]) begin
        found = 1'b1;
        idx   = IDXW'(i);
      end
    end
  end

endmodule : prio_pick
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prio_arbiter
// Description : Registered N-way arbiter with fixed-priority (highest index
//               wins) and round-robin modes and a valid/ready output holding
//               the winner until the consumer accepts it.
// Ports       : clk               rising-edge clock
//               rst_n             asynchronous active-low reset
//               req   [N-1:0]     pending requests
//               mode              0 = fixed priority, 1 = round-robin
//               out_idx [IDXW-1:0] registered winner index
//               grant [N-1:0]     one-hot winner, zero when !out_valid
//               out_valid         out_idx/grant hold a winner
//               out_ready         consumer accepts the current winner
// Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter
  import prio_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  output logic [IDXW-1:0] out_idx,
  output logic [N-1:0]    grant,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [IDXW-1:0] PTR_RESET = IDXW'(N - 1);

  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_valid_q, out_valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic            accept;
  logic            select;
  logic [N-1:0]    rr_mask;
  logic            masked_found, full_found;
  logic [IDXW-1:0] masked_idx, full_idx, win_idx;

  assign accept = out_valid_q && out_ready;
  assign select = !out_valid_q || out_ready;

  // Pointer moves one below the winner being accepted, wrapping 0 -> N-1.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (out_idx_q == '0) ? PTR_RESET : out_idx_q - 1'b1;
    end
  end

  // The round-robin mask uses the pointer value that takes effect at this
  // edge, so an accept and the next pick in the same cycle already rotate.
  for (genvar i = 0; i < N; i++) begin : g_mask
    assign rr_mask[i] = (i <= int'(ptr_d));
  end

  prio_pick #(.N(N), .IDXW(IDXW)) u_pick_masked (
    .req   (req),
    .mask  (rr_mask),
    .found (masked_found),
    .idx   (masked_idx)
  );

  prio_pick #(.N(N), .IDXW(IDXW)) u_pick_full (
    .req   (req),
    .mask  ({N{1'b1}}),
    .found (full_found),
    .idx   (full_idx)
  );

  // With no request at or below the pointer, round-robin wraps to the top.
  assign win_idx = ((mode == MODE_RR) && masked_found) ? masked_idx : full_idx;

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (select) begin
      out_valid_d = full_found;
      out_idx_d   = full_found ? win_idx : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= PTR_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_grant
    assign grant[i] = out_valid_q && (out_idx_q == IDXW'(i));
  end

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;

endmodule : prio_arbiter
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_arbiter
// Description : Self-checking bench for prio_arbiter (N=4). Stimulus pushes
//               expected accepted winners into a scoreboard queue; a monitor
//               pops and compares on every accepted transfer. Stall, idle and
//               reset states are compared directly by the stimulus process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter;

  localparam int N    = 4;
  localparam int IDXW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic            mode;
  logic [IDXW-1:0] out_idx;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic            out_ready;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] ptr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  prio_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .out_idx   (out_idx),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDXW-1:0] idx, input logic [N-1:0] gnt,
                      input logic [IDXW-1:0] ptr);
    exp_t e;
    e.idx = idx;
    e.gnt = gnt;
    e.ptr = ptr;
    sb.push_back(e);
  endtask

  task automatic check_state(input string name, input logic v, input logic [IDXW-1:0] idx,
                             input logic [N-1:0] gnt, input logic [IDXW-1:0] ptr);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    check({name, "_idx"},   32'(out_idx),   32'(idx));
    check({name, "_grant"}, 32'(grant),     32'(gnt));
    check({name, "_ptr"},   32'(dut.ptr_q), 32'(ptr));
  endtask

  // Ends the previous test (scoreboard must be drained), resets, releases.
  task automatic do_reset(input string name);
    check({name, "_sb_drain"}, 32'(sb.size()), 32'd0);
    rst_n     = 1'b0;
    req       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    cycles(1);
    check_state({name, "_rst"}, 1'b0, 2'd0, 4'b0000, 2'd3);
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_accept", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_idx",   32'(out_idx),   32'(e.idx));
        check("sb_grant", 32'(grant),     32'(e.gnt));
        check("sb_ptr",   32'(dut.ptr_q), 32'(e.ptr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; mode = 1'b0; out_ready = 1'b0;
    cycles(1);

    // Fixed priority, all requesting: 3 every cycle; ptr settles at 2.
    do_reset("t_fixed");
    mode = 1'b0; req = 4'b1111; out_ready = 1'b1;
    push(2'd3, 4'b1000, 2'd3);
    push(2'd3, 4'b1000, 2'd2);
    push(2'd3, 4'b1000, 2'd2);
    push(2'd3, 4'b1000, 2'd2);
    cycles(5);

    // Round-robin from reset: 3,2,1,0,3 with ptr 3,2,1,0,3 at each accept.
    do_reset("t_rr");
    mode = 1'b1; req = 4'b1111; out_ready = 1'b1;
    push(2'd3, 4'b1000, 2'd3);
    push(2'd2, 4'b0100, 2'd2);
    push(2'd1, 4'b0010, 2'd1);
    push(2'd0, 4'b0001, 2'd0);
    push(2'd3, 4'b1000, 2'd3);
    cycles(6);

    // Stall holds winner 2 while req changes to 1000; then 3 after accept.
    do_reset("t_stall");
    mode = 1'b1; req = 4'b0101; out_ready = 1'b0;
    cycles(1);
    check_state("t_stall_first", 1'b1, 2'd2, 4'b0100, 2'd3);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      cycles(1);
      check_state("t_stall_hold", 1'b1, 2'd2, 4'b0100, 2'd3);
    end
    push(2'd2, 4'b0100, 2'd3);
    push(2'd3, 4'b1000, 2'd1);
    out_ready = 1'b1;
    cycles(2);

    // Idle selection, then single request 0 and pointer wrap to N-1.
    do_reset("t_idle");
    mode = 1'b0; req = 4'b0000; out_ready = 1'b1;
    cycles(1);
    check_state("t_idle_empty", 1'b0, 2'd0, 4'b0000, 2'd3);
    req = 4'b0001;
    push(2'd0, 4'b0001, 2'd3);
    push(2'd0, 4'b0001, 2'd3);
    cycles(1);
    check_state("t_idle_one", 1'b1, 2'd0, 4'b0001, 2'd3);
    cycles(2);

    // Asynchronous reset mid-stall discards winner; fresh pick afterwards.
    do_reset("t_async");
    mode = 1'b1; req = 4'b0100; out_ready = 1'b0;
    cycles(2);
    check_state("t_async_stall", 1'b1, 2'd2, 4'b0100, 2'd3);
    rst_n = 1'b0;
    #2;
    check_state("t_async_rst", 1'b0, 2'd0, 4'b0000, 2'd3);
    req = 4'b0110; mode = 1'b1; out_ready = 1'b1;
    push(2'd2, 4'b0100, 2'd3);
    push(2'd1, 4'b0010, 2'd1);
    rst_n = 1'b1;
    cycles(3);

    // Mode switch during a stall takes effect at the next selection only.
    do_reset("t_mode");
    mode = 1'b0; req = 4'b1111; out_ready = 1'b0;
    cycles(1);
    check_state("t_mode_first", 1'b1, 2'd3, 4'b1000, 2'd3);
    mode = 1'b1;
    cycles(2);
    check_state("t_mode_hold", 1'b1, 2'd3, 4'b1000, 2'd3);
    push(2'd3, 4'b1000, 2'd3);
    push(2'd2, 4'b0100, 2'd2);
    out_ready = 1'b1;
    cycles(2);

    do_reset("t_end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prio_arbiter
`default_nettype wire
